// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants and helpers for the pipelined carry-save
//               array multiplier: pipeline geometry, Baugh-Wooley correction
//               constant and stage-register field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Number of array rows evaluated between two pipeline registers
    function automatic int rows_per_stage(input int n, input int stages);
        return n / stages;
    endfunction

    // Legal configuration: N >= 2, STAGES in 1..N and STAGES divides N
    function automatic bit stage_cfg_ok(input int n, input int stages);
        return (n >= 2) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

    // Baugh-Wooley correction constant, one bit at a time: ones at N and 2N-1
    function automatic logic bw_corr_bit(input int n, input int pos);
        return (pos == n) || (pos == (2 * n - 1));
    endfunction

    // Stage-register layout, LSB first:
    // psum[2N] | carry[N] | x[N] | y[N] | signed | valid
    localparam int SR_PSUM_LSB = 0;

    function automatic int sr_carry_lsb(input int n);
        return 2 * n;
    endfunction

    function automatic int sr_x_lsb(input int n);
        return 3 * n;
    endfunction

    function automatic int sr_y_lsb(input int n);
        return 4 * n;
    endfunction

    function automatic int sr_sgn_bit(input int n);
        return 5 * n;
    endfunction

    function automatic int sr_vld_bit(input int n);
        return 5 * n + 1;
    endfunction

    function automatic int sr_width(input int n);
        return 5 * n + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_row.sv
`default_nettype none
// ============================================================================
// Module      : mult_row
// Description : One row of the carry-save array: N AND-gate / full-adder
//               cells folding partial-product row row_idx into the running
//               partial-sum and carry vectors. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_row
    import mult_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     x,
    input  logic             y_bit,
    input  logic [2*N-1:0]   psum_in,
    input  logic [N-1:0]     carry_in,
    input  logic             is_signed,
    input  logic [IDX_W-1:0] row_idx,
    output logic [2*N-1:0]   psum_out,
    output logic [N-1:0]     carry_out
);

    // Bit-position width covering 0..2N-1
    localparam int c_pos_w = IDX_W + 1;

    // Invariant: value = psum + sum(carry[j] << (row + j)). Cell j of row i
    // adds psum[i+j], pp[i][j] and carry[j]; its carry lands at weight
    // (i+1)+j, which is exactly where the next row expects carry[j].
    always_comb begin
        logic [c_pos_w-1:0] w_pos;
        logic               w_pp;
        psum_out  = psum_in;
        carry_out = '0;
        w_pos     = '0;
        w_pp      = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_pos = c_pos_w'(row_idx) + c_pos_w'(j);
            w_pp  = x[j] & y_bit;
            // Baugh-Wooley: invert partial products in the MSB row or MSB
            // column, but not the corner bit where both meet
            if (is_signed && ((row_idx == IDX_W'(N - 1)) != (j == N - 1))) begin
                w_pp = ~w_pp;
            end
            psum_out[w_pos] = psum_in[w_pos] ^ w_pp ^ carry_in[j];
            carry_out[j]    = (psum_in[w_pos] & w_pp)
                            | (psum_in[w_pos] & carry_in[j])
                            | (w_pp & carry_in[j]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_array_mult.sv
`default_nettype none
// ============================================================================
// Module      : pipe_array_mult
// Description : Pipelined carry-save array multiplier with per-transaction
//               signed/unsigned mode and valid/ready handshakes. STAGES
//               register stages, each evaluating N/STAGES array rows; the
//               last stage also does the carry-propagate add into out_z.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_array_mult
    import mult_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_y,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_z
);

    localparam int c_rows     = rows_per_stage(N, STAGES);
    localparam int c_idx_w    = $clog2(N);
    localparam int c_sw       = sr_width(N);
    localparam int c_carry_lsb = sr_carry_lsb(N);
    localparam int c_x_lsb    = sr_x_lsb(N);
    localparam int c_y_lsb    = sr_y_lsb(N);
    localparam int c_sgn_bit  = sr_sgn_bit(N);
    localparam int c_vld_bit  = sr_vld_bit(N);

    if (!stage_cfg_ok(N, STAGES)) begin : g_cfg_check
        $error("pipe_array_mult: STAGES must lie in 1..N and divide N");
    end

    logic             w_adv;
    logic [2*N-1:0]   w_bw_corr;
    // w_src[k] is the word stage k consumes: the inputs for k = 0, else the
    // register of stage k-1
    logic [c_sw-1:0]  w_src [STAGES];

    // Whole pipeline moves together; a stalled output freezes every stage
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    genvar b;
    for (b = 0; b < 2 * N; b++) begin : g_corr
        assign w_bw_corr[b] = bw_corr_bit(N, b);
    end

    // Signed transactions start with the correction constant preloaded as the
    // partial sum so no extra adder row is needed
    assign w_src[0] = {in_valid, in_signed, in_y, in_x, {N{1'b0}},
                       (in_signed ? w_bw_corr : {2*N{1'b0}})};

    genvar k, r;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic [2*N-1:0] w_ps [c_rows+1];
        logic [N-1:0]   w_cy [c_rows+1];
        logic [N-1:0]   w_x;
        logic           w_sgn;
        logic           w_vld;

        assign w_x     = w_src[k][c_x_lsb +: N];
        assign w_sgn   = w_src[k][c_sgn_bit];
        assign w_vld   = w_src[k][c_vld_bit];
        assign w_ps[0] = w_src[k][SR_PSUM_LSB +: 2*N];
        assign w_cy[0] = w_src[k][c_carry_lsb +: N];

        for (r = 0; r < c_rows; r++) begin : g_row
            mult_row #(
                .N     (N),
                .IDX_W (c_idx_w)
            ) u_row (
                .x         (w_x),
                .y_bit     (w_src[k][c_y_lsb + k*c_rows + r]),
                .psum_in   (w_ps[r]),
                .carry_in  (w_cy[r]),
                .is_signed (w_sgn),
                .row_idx   (c_idx_w'(k*c_rows + r)),
                .psum_out  (w_ps[r+1]),
                .carry_out (w_cy[r+1])
            );
        end

        if (k < STAGES - 1) begin : g_mid
            logic [c_sw-1:0] r_stage;

            // Intermediate stage register: carry-save state plus operands
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stage <= '0;
                end else if (w_adv) begin
                    r_stage <= {w_vld, w_sgn, w_src[k][c_y_lsb +: N], w_x,
                                w_cy[c_rows], w_ps[c_rows]};
                end
            end

            assign w_src[k+1] = r_stage;
        end else begin : g_last
            logic [2*N-1:0] w_prod;

            // Carry vector after the final row sits at weights N..2N-1
            assign w_prod = w_ps[c_rows] + {w_cy[c_rows], {N{1'b0}}};

            // Output register; bubbles leave the previous product in place
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_z     <= '0;
                end else if (w_adv) begin
                    out_valid <= w_vld;
                    if (w_vld) begin
                        out_z <= w_prod;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
